// File: rtl/sdram_stream_dma.sv
// Single-beat Avalon-MM DMA between a valid/ready stream and the SDRAM sdout slave.
// States: IDLE wait for cmd | WRITE stream->SDRAM | READ issue reads | DRAIN empty FIFO | DONE one-cycle pulse
module sdram_stream_dma #(
  parameter int ADDR_W     = 28,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  cmd_start,
  input  logic                  cmd_dir,
  input  logic [ADDR_W-1:0]     cmd_base,
  input  logic [LEN_W-1:0]      cmd_len,
  output logic                  busy,
  output logic                  done,
  input  logic [DATA_W-1:0]     snk_data,
  input  logic                  snk_valid,
  output logic                  snk_ready,
  output logic [DATA_W-1:0]     src_data,
  output logic                  src_valid,
  input  logic                  src_ready,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W-1:0]     avm_writedata,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic                  avm_burstcount,
  output logic                  avm_debugaccess,
  input  logic                  avm_waitrequest,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_readdatavalid
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [LEN_W-1:0]    cnt_a_q, cnt_a_d;   // write: words taken from sink; read: reads issued
  logic [LEN_W-1:0]    cnt_b_q, cnt_b_d;   // write: words written; read: words delivered
  logic [CW-1:0]       pend_q, pend_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                en_q;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];

  logic in_wr, in_rd, in_src, fifo_empty, fifo_full;
  logic snk_hs, wr_acc, rd_acc, rdv_push, src_hs, push, pop;
  logic [CW:0]         occupancy;
  logic [DATA_W-1:0]   head, push_data;

  assign in_wr      = (state_q == S_WRITE);
  assign in_rd      = (state_q == S_READ);
  assign in_src     = (state_q == S_READ) || (state_q == S_DRAIN);
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
  assign head       = mem[rd_ptr_q];

  // Outstanding reads plus stored words never exceed the FIFO, so every response has a slot.
  assign occupancy  = {1'b0, pend_q} + {1'b0, count_q};

  assign snk_ready  = in_wr && !fifo_full && (cnt_a_q < len_q);
  assign snk_hs     = snk_valid && snk_ready;
  assign avm_write  = in_wr && !fifo_empty;
  assign wr_acc     = avm_write && !avm_waitrequest;
  assign avm_read   = in_rd && (cnt_a_q < len_q) && (occupancy < (CW+1)'(FIFO_DEPTH));
  assign rd_acc     = avm_read && !avm_waitrequest;
  assign rdv_push   = in_src && avm_readdatavalid;
  assign src_valid  = in_src && !fifo_empty;
  assign src_hs     = src_valid && src_ready;
  assign push       = snk_hs || rdv_push;
  assign pop        = wr_acc || src_hs;
  assign push_data  = in_wr ? snk_data : avm_readdata;

  assign avm_writedata   = avm_write ? head : '0;
  assign src_data        = src_valid ? head : '0;
  assign avm_address     = addr_q;
  assign avm_byteenable  = {(DATA_W/8){en_q}};
  assign avm_burstcount  = en_q;
  assign avm_debugaccess = 1'b0;
  assign busy            = in_wr || in_src;
  assign done            = (state_q == S_DONE);

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    addr_d   = addr_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    pend_d   = pend_q;
    wr_ptr_d = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(push) - CW'(pop);
    case (state_q)
      S_IDLE: begin
        if (cmd_start) begin
          len_d   = cmd_len;
          addr_d  = cmd_base & ~ADDR_W'(3);
          cnt_a_d = '0;
          cnt_b_d = '0;
          pend_d  = '0;
          if (cmd_len == '0) state_d = S_DONE;
          else if (cmd_dir)  state_d = S_READ;
          else               state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        if (snk_hs) cnt_a_d = cnt_a_q + LEN_W'(1);
        if (wr_acc) begin
          addr_d  = addr_q + ADDR_W'(4);
          cnt_b_d = cnt_b_q + LEN_W'(1);
          if (cnt_b_q == len_q - LEN_W'(1)) state_d = S_DONE;
        end
      end
      S_READ, S_DRAIN: begin
        pend_d = pend_q + CW'(rd_acc) - CW'(rdv_push);
        if (rd_acc) begin
          addr_d  = addr_q + ADDR_W'(4);
          cnt_a_d = cnt_a_q + LEN_W'(1);
          if (cnt_a_q + LEN_W'(1) == len_q) state_d = S_DRAIN;
        end
        if (src_hs) begin
          cnt_b_d = cnt_b_q + LEN_W'(1);
          if (state_q == S_DRAIN && cnt_b_q == len_q - LEN_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      addr_q   <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      pend_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      addr_q   <= addr_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      pend_q   <= pend_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      en_q     <= 1'b1;
    end
  end

  // Storage needs no reset: validity is tracked by count_q alone.
  always_ff @(posedge clk_clk) begin
    if (push) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: tb/tb_sdram_stream_dma.sv
// Directed bench for sdram_stream_dma with a small Avalon slave model and stream monitors.
module tb_sdram_stream_dma;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cmd_start, cmd_dir;
  logic [27:0] cmd_base;
  logic [15:0] cmd_len;
  logic        busy, done;
  logic [31:0] snk_data;
  logic        snk_valid, snk_ready;
  logic [31:0] src_data;
  logic        src_valid, src_ready;
  logic [27:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic        avm_burstcount, avm_debugaccess;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;

  always #5 clk = ~clk;

  sdram_stream_dma dut (
    .clk_clk(clk), .reset_reset_n(rst_n),
    .cmd_start(cmd_start), .cmd_dir(cmd_dir), .cmd_base(cmd_base), .cmd_len(cmd_len),
    .busy(busy), .done(done),
    .snk_data(snk_data), .snk_valid(snk_valid), .snk_ready(snk_ready),
    .src_data(src_data), .src_valid(src_valid), .src_ready(src_ready),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
    .avm_burstcount(avm_burstcount), .avm_debugaccess(avm_debugaccess),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid)
  );

  // Controls written by the stimulus block only
  logic wait_force = 1'b0, stall_en = 1'b0, rd_lim_en = 1'b0, resp_en = 1'b1, late_v = 1'b0;
  int   stall_at = 0, stall_lim = 0, rd_lim = 0;

  // Slave model / monitor state written by the monitor only
  int          cyc = 0, n_wr_acc = 0, n_rd_acc = 0, stall_cnt = 0, hold_err = 0;
  int          done_cnt = 0, done_cyc = 0, last_acc_cyc = 0, start_cyc = 0, rw_cnt = 0;
  logic        prev_stall = 1'b0, s1_v = 1'b0, rdv_q = 1'b0;
  logic [27:0] held_a = '0, s1_a = '0;
  logic [31:0] held_d = '0, rdata_q = '0;
  logic [27:0] wr_a[$];
  logic [31:0] wr_d[$];
  logic [31:0] out_q[$];

  int tests = 0, fails = 0;

  function automatic logic [31:0] mem_f(input logic [27:0] a);
    return {4'hC, a};
  endfunction

  assign avm_waitrequest   = wait_force
                           | (stall_en && n_wr_acc == stall_at && stall_cnt < stall_lim)
                           | (rd_lim_en && n_rd_acc >= rd_lim);
  assign avm_readdatavalid = rdv_q | late_v;
  assign avm_readdata      = late_v ? 32'hDEADBEEF : rdata_q;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (avm_write && !avm_waitrequest) begin
      n_wr_acc <= n_wr_acc + 1;
      wr_a.push_back(avm_address);
      wr_d.push_back(avm_writedata);
      last_acc_cyc <= cyc;
    end
    if (avm_write && avm_waitrequest) begin
      stall_cnt <= stall_cnt + 1;
      if (prev_stall && (avm_address !== held_a || avm_writedata !== held_d)) hold_err <= hold_err + 1;
      held_a <= avm_address;
      held_d <= avm_writedata;
    end
    prev_stall <= avm_write && avm_waitrequest;
    if (avm_read && !avm_waitrequest) n_rd_acc <= n_rd_acc + 1;
    s1_v    <= avm_read && !avm_waitrequest && resp_en;
    s1_a    <= avm_address;
    rdv_q   <= s1_v;
    rdata_q <= mem_f(s1_a);
    if (src_valid && src_ready) out_q.push_back(src_data);
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (cmd_start) start_cyc <= cyc;
    if (avm_read || avm_write) rw_cnt <= rw_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic dir, input logic [27:0] base, input logic [15:0] len);
    cmd_dir = dir; cmd_base = base; cmd_len = len; cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
  endtask

  task automatic send(input logic [31:0] w[4], input int n);
    int i = 0;
    int g = 0;
    while (i < n && g < 200) begin
      snk_valid = 1'b1;
      snk_data  = w[i];
      if (snk_ready) i++;
      @(negedge clk);
      g++;
    end
    snk_valid = 1'b0;
    chk("send_budget", 64'(i), 64'(n));
  endtask

  task automatic wait_done(input string tag);
    int g = 0;
    while (!done && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk({tag, "_done_seen"}, 64'(done), 64'd1);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, 64'({done, busy}), 64'd0);
  endtask

  initial begin
    logic [31:0] w[4];
    int wa0, dc0, sc0, rc0, oq0, rw0;
    rst_n = 1'b0; cmd_start = 1'b0; cmd_dir = 1'b0; cmd_base = '0; cmd_len = '0;
    snk_data = '0; snk_valid = 1'b0; src_ready = 1'b0;
    #23;
    chk("rst_ctrl", 64'({avm_read, avm_write, busy, done, snk_ready, src_valid,
                         avm_byteenable, avm_burstcount, avm_debugaccess}), 64'd0);
    chk("rst_data", 64'({avm_address, avm_writedata, src_data}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("consts", 64'({avm_byteenable, avm_burstcount, avm_debugaccess}), 64'b111110);
    chk("idle_busy", 64'(busy), 64'd0);

    // Test 1: plain write
    wa0 = wr_a.size(); dc0 = done_cnt;
    start(1'b0, 28'h100, 16'd4);
    chk("t1_busy", 64'(busy), 64'd1);
    w[0] = 32'hA0; w[1] = 32'hA1; w[2] = 32'hA2; w[3] = 32'hA3;
    send(w, 4);
    wait_done("t1");
    chk("t1_nwr", 64'(wr_a.size() - wa0), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t1_addr%0d", i), 64'(wr_a[wa0+i]), 64'(28'h100 + 28'(4*i)));
      chk($sformatf("t1_data%0d", i), 64'(wr_d[wa0+i]), 64'(32'hA0 + 32'(i)));
    end
    chk("t1_done_lat", 64'(done_cyc), 64'(last_acc_cyc + 1));
    chk("t1_done_cnt", 64'(done_cnt - dc0), 64'd1);

    // Test 2: write with a 3-cycle stall on the 2nd word
    wa0 = wr_a.size(); sc0 = stall_cnt;
    stall_at = n_wr_acc + 1; stall_lim = stall_cnt + 3; stall_en = 1'b1;
    start(1'b0, 28'h200, 16'd3);
    w[0] = 32'hB0; w[1] = 32'hB1; w[2] = 32'hB2; w[3] = '0;
    send(w, 3);
    wait_done("t2");
    stall_en = 1'b0;
    chk("t2_nwr", 64'(wr_a.size() - wa0), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t2_addr%0d", i), 64'(wr_a[wa0+i]), 64'(28'h200 + 28'(4*i)));
      chk($sformatf("t2_data%0d", i), 64'(wr_d[wa0+i]), 64'(32'hB0 + 32'(i)));
    end
    chk("t2_stalls", 64'(stall_cnt - sc0), 64'd3);
    chk("t2_hold", 64'(hold_err), 64'd0);

    // Test 3: read len 20 against a 16-deep FIFO with the sink stalled
    rc0 = n_rd_acc; oq0 = out_q.size();
    src_ready = 1'b0;
    start(1'b1, 28'h1000, 16'd20);
    repeat (40) @(negedge clk);
    chk("t3_credit_reads", 64'(n_rd_acc - rc0), 64'd16);
    chk("t3_read_low", 64'(avm_read), 64'd0);
    chk("t3_busy", 64'(busy), 64'd1);
    src_ready = 1'b1;
    wait_done("t3");
    src_ready = 1'b0;
    chk("t3_total_reads", 64'(n_rd_acc - rc0), 64'd20);
    chk("t3_nout", 64'(out_q.size() - oq0), 64'd20);
    for (int i = 0; i < 20; i++)
      chk($sformatf("t3_out%0d", i), 64'(out_q[oq0+i]), 64'(mem_f(28'h1000 + 28'(4*i))));

    // Test 4: zero-length commands in both directions
    rw0 = rw_cnt;
    start(1'b0, 28'h400, 16'd0);
    chk("t4_done", 64'({done, busy}), 64'b10);
    @(negedge clk);
    chk("t4_done_low", 64'(done), 64'd0);
    chk("t4_done_lat", 64'(done_cyc), 64'(start_cyc + 1));
    start(1'b1, 28'h400, 16'd0);
    chk("t4r_done", 64'({done, busy}), 64'b10);
    @(negedge clk);
    chk("t4_no_rw", 64'(rw_cnt - rw0), 64'd0);

    // Test 5: address wrap
    wa0 = wr_a.size();
    start(1'b0, 28'hFFFFFFC, 16'd2);
    w[0] = 32'h11; w[1] = 32'h22; w[2] = '0; w[3] = '0;
    send(w, 2);
    wait_done("t5");
    chk("t5_nwr", 64'(wr_a.size() - wa0), 64'd2);
    chk("t5_addr0", 64'(wr_a[wa0]), 64'(28'hFFFFFFC));
    chk("t5_addr1", 64'(wr_a[wa0+1]), 64'd0);
    chk("t5_data1", 64'(wr_d[wa0+1]), 64'h22);

    // Test 6: reset with three reads outstanding
    resp_en = 1'b0; rc0 = n_rd_acc; rd_lim = n_rd_acc + 3; rd_lim_en = 1'b1;
    oq0 = out_q.size();
    start(1'b1, 28'h2000, 16'd8);
    repeat (8) @(negedge clk);
    chk("t6_pending_reads", 64'(n_rd_acc - rc0), 64'd3);
    chk("t6_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_ctrl", 64'({avm_read, avm_write, busy, done, snk_ready, src_valid,
                            avm_byteenable, avm_burstcount, avm_debugaccess}), 64'd0);
    chk("t6_rst_addr", 64'(avm_address), 64'd0);
    rd_lim_en = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); late_v = 1'b1;
    repeat (3) @(negedge clk);
    late_v = 1'b0;
    @(negedge clk);
    chk("t6_late_ignored", 64'({src_valid, busy, done}), 64'd0);
    chk("t6_no_out", 64'(out_q.size() - oq0), 64'd0);
    resp_en = 1'b1; src_ready = 1'b1;
    start(1'b1, 28'h3000, 16'd2);
    wait_done("t6");
    chk("t6_nout", 64'(out_q.size() - oq0), 64'd2);
    chk("t6_out0", 64'(out_q[oq0]), 64'(mem_f(28'h3000)));
    chk("t6_out1", 64'(out_q[oq0+1]), 64'(mem_f(28'h3004)));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
